wb_mux: RTL and testbench

//   Writeback-stage selector for the simple_cpu integer pipeline.
//   - Picks the register-file write data from ALU, load, PC+4 or CSR sources.
//   - Qualifies the write enable with kill and x0 suppression.
//   - Holds a one-entry registered copy of the last committed write, used for
//     WB->ID forwarding and debug.

---
 rtl/wb_mux_pkg.sv | 30 +++
 rtl/wb_mux_hist_reg.sv | 53 +++++
 rtl/wb_mux.sv | 97 +++++++++
 tb/tb_wb_mux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/wb_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mux_pkg
//  Purpose  : Shared writeback definitions: datapath width, register index
//             width, writeback source-select encodings and the write-enable
//             qualification rule. The pipeline decoder and the writeback
//             stage use the same encodings.
//  Revision : 1.0  initial release
// ============================================================================
package wb_mux_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int REG_IDX_W  = 5;

   // Writeback source select encodings
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] WB_CSR = 2'd3;

   // A write commits only if it was decoded as a write, was not squashed,
   // and does not target x0 (which is hardwired to zero).
   function automatic logic qualify_we(input logic           regwrite,
                                       input logic           kill,
                                       input logic [REG_IDX_W-1:0] rd);
      return regwrite & ~kill & (rd != '0);
   endfunction

endpackage : wb_mux_pkg
`default_nettype wire

// File: rtl/wb_mux_hist_reg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_hist_reg
//  Purpose  : One-entry history register holding the last committed
//             register-file write (used for WB->ID forwarding and debug).
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             i_we            - a write commits this cycle
//             i_rd / i_data   - index and data of that write
//             o_valid         - a write committed in the previous cycle
//             o_rd / o_data   - index and data of the last committed write
//  Revision : 1.0  initial release
// ============================================================================
module wb_hist_reg
   import wb_mux_pkg::*;
#(
   parameter int DATA_WIDTH = wb_mux_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_we,
   input  logic [REG_IDX_W-1:0]  i_rd,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   output logic [REG_IDX_W-1:0]  o_rd,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic                  r_valid;
   logic [REG_IDX_W-1:0]  r_rd;
   logic [DATA_WIDTH-1:0] r_data;

   // Valid tracks the enable every cycle; index/data only move on a real
   // commit so a squashed or x0 write leaves the last committed entry intact.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_rd    <= '0;
         r_data  <= '0;
      end else begin
         r_valid <= i_we;
         if (i_we) begin
            r_rd   <= i_rd;
            r_data <= i_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_rd    = r_rd;
   assign o_data  = r_data;

endmodule : wb_hist_reg
`default_nettype wire

// File: rtl/wb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mux
//  Purpose  : Writeback-stage selector for the simple_cpu integer pipeline.
//             Selects register-file write data from ALU / load / PC+4 / CSR,
//             qualifies the write enable (kill, x0 suppression) and keeps a
//             registered copy of the last committed write.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             i_alu_result      - ALU result            (WB_ALU)
//             i_load_rdata      - aligned load data     (WB_MEM)
//             i_pc_plus4        - link address          (WB_PC4)
//             i_csr_rdata       - CSR read data         (WB_CSR)
//             i_wb_sel          - source select
//             i_regwrite        - decoded write enable
//             i_kill_wb         - squash of this instruction
//             i_rd              - destination register index
//             o_rd_wdata        - selected write data (combinational)
//             o_regwrite        - qualified write enable (combinational)
//             o_rd              - i_rd passthrough (combinational)
//             o_wbq_valid/rd/data - last committed write (registered)
//  Revision : 1.0  initial release
// ============================================================================
module wb_mux
   import wb_mux_pkg::*;
#(
   parameter int DATA_WIDTH = wb_mux_pkg::DATA_WIDTH,
   parameter bit HAS_CSR    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] i_alu_result,
   input  logic [DATA_WIDTH-1:0] i_load_rdata,
   input  logic [DATA_WIDTH-1:0] i_pc_plus4,
   input  logic [DATA_WIDTH-1:0] i_csr_rdata,
   input  logic [1:0]            i_wb_sel,
   input  logic                  i_regwrite,
   input  logic                  i_kill_wb,
   input  logic [REG_IDX_W-1:0]  i_rd,
   output logic [DATA_WIDTH-1:0] o_rd_wdata,
   output logic                  o_regwrite,
   output logic [REG_IDX_W-1:0]  o_rd,
   output logic                  o_wbq_valid,
   output logic [REG_IDX_W-1:0]  o_wbq_rd,
   output logic [DATA_WIDTH-1:0] o_wbq_data
);

   logic [DATA_WIDTH-1:0] w_csr_src;
   logic [DATA_WIDTH-1:0] w_rd_wdata;
   logic                  w_regwrite;

   // CSR arm: without CSR support the source reads as all-zeros, but the
   // select code stays legal and still produces a (zero) write.
   generate
      if (HAS_CSR) begin : g_csr_en
         assign w_csr_src = i_csr_rdata;
      end else begin : g_csr_dis
         assign w_csr_src = '0;
         logic w_unused_csr;
         assign w_unused_csr = ^i_csr_rdata;
      end
   endgenerate

   // The X default is deliberate: an unknown select propagates as unknown
   // data in simulation instead of being masked to a plausible value.
   always_comb begin
      w_rd_wdata = 'x;
      case (i_wb_sel)
         WB_ALU: w_rd_wdata = i_alu_result;
         WB_MEM: w_rd_wdata = i_load_rdata;
         WB_PC4: w_rd_wdata = i_pc_plus4;
         WB_CSR: w_rd_wdata = w_csr_src;
         default: w_rd_wdata = 'x;
      endcase
   end

   // Data is never gated by the enable; consumers must look at o_regwrite.
   assign w_regwrite = qualify_we(i_regwrite, i_kill_wb, i_rd);

   assign o_rd_wdata = w_rd_wdata;
   assign o_regwrite = w_regwrite;
   assign o_rd       = i_rd;

   wb_hist_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_hist (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_regwrite),
      .i_rd    (i_rd),
      .i_data  (w_rd_wdata),
      .o_valid (o_wbq_valid),
      .o_rd    (o_wbq_rd),
      .o_data  (o_wbq_data)
   );

endmodule : wb_mux
`default_nettype wire

// File: tb/tb_wb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_mux
//  Purpose  : Self-checking bench for wb_mux: table of combinational vectors
//             on a HAS_CSR=1 and a HAS_CSR=0 instance, plus hand-written
//             multi-cycle sequences for the history register checked through
//             an expected-value queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_mux;

   localparam int DW = 32;
   localparam logic [DW-1:0] SRC_ALU = 32'hA1A1_A1A1;
   localparam logic [DW-1:0] SRC_MEM = 32'hB2B2_B2B2;
   localparam logic [DW-1:0] SRC_PC4 = 32'hC3C3_C3C3;
   localparam logic [DW-1:0] SRC_CSR = 32'hD4D4_D4D4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] alu_result = SRC_ALU;
   logic [DW-1:0] load_rdata = SRC_MEM;
   logic [DW-1:0] pc_plus4   = SRC_PC4;
   logic [DW-1:0] csr_rdata  = SRC_CSR;
   logic [1:0]    wb_sel     = 2'd0;
   logic          regwrite   = 1'b0;
   logic          kill_wb    = 1'b0;
   logic [4:0]    rd_in      = 5'd0;

   logic [DW-1:0] a_wdata, b_wdata, a_qdata, b_qdata;
   logic          a_we, b_we, a_qvalid, b_qvalid;
   logic [4:0]    a_rd, b_rd, a_qrd, b_qrd;

   always #5 clk = ~clk;

   wb_mux #(.DATA_WIDTH(DW), .HAS_CSR(1'b1)) u_dut_csr (
      .clk(clk), .rst(rst),
      .i_alu_result(alu_result), .i_load_rdata(load_rdata),
      .i_pc_plus4(pc_plus4), .i_csr_rdata(csr_rdata),
      .i_wb_sel(wb_sel), .i_regwrite(regwrite), .i_kill_wb(kill_wb),
      .i_rd(rd_in),
      .o_rd_wdata(a_wdata), .o_regwrite(a_we), .o_rd(a_rd),
      .o_wbq_valid(a_qvalid), .o_wbq_rd(a_qrd), .o_wbq_data(a_qdata)
   );

   wb_mux #(.DATA_WIDTH(DW), .HAS_CSR(1'b0)) u_dut_nocsr (
      .clk(clk), .rst(rst),
      .i_alu_result(alu_result), .i_load_rdata(load_rdata),
      .i_pc_plus4(pc_plus4), .i_csr_rdata(csr_rdata),
      .i_wb_sel(wb_sel), .i_regwrite(regwrite), .i_kill_wb(kill_wb),
      .i_rd(rd_in),
      .o_rd_wdata(b_wdata), .o_regwrite(b_we), .o_rd(b_rd),
      .o_wbq_valid(b_qvalid), .o_wbq_rd(b_qrd), .o_wbq_data(b_qdata)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Combinational vector table (HAS_CSR=1 instance)
   typedef struct {
      logic [1:0]    sel;
      logic          rw;
      logic          kill;
      logic [4:0]    rd;
      logic [DW-1:0] exp_wdata;
      logic          exp_we;
      logic [4:0]    exp_rd;
   } vec_t;

   vec_t vecs[$];

   // History-register expectations
   typedef struct {
      logic          valid;
      logic [4:0]    rd;
      logic [DW-1:0] data;
   } hist_t;

   hist_t         sb[$];
   logic [4:0]    m_rd   = '0;
   logic [DW-1:0] m_data = '0;

   function automatic logic [DW-1:0] src_of(input logic [1:0] s);
      case (s)
         2'd0:    return SRC_ALU;
         2'd1:    return SRC_MEM;
         2'd2:    return SRC_PC4;
         default: return SRC_CSR;
      endcase
   endfunction

   // Drive one cycle, predict the history register, check it after the edge.
   task automatic step(input string tag, input logic r, input logic [1:0] s,
                       input logic rw, input logic k, input logic [4:0] d);
      hist_t e;
      logic  we;
      hist_t got;
      @(negedge clk);
      rst = r; wb_sel = s; regwrite = rw; kill_wb = k; rd_in = d;
      we = rw & ~k & (d != 5'd0);
      if (r) begin
         m_rd = '0; m_data = '0; e.valid = 1'b0;
      end else begin
         e.valid = we;
         if (we) begin
            m_rd = d; m_data = src_of(s);
         end
      end
      e.rd = m_rd; e.data = m_data;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check({tag, ".wbq_valid"}, {31'd0, a_qvalid}, {31'd0, got.valid});
      check({tag, ".wbq_rd"},    {27'd0, a_qrd},    {27'd0, got.rd});
      check({tag, ".wbq_data"},  a_qdata,           got.data);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs.push_back('{2'd0, 1'b1, 1'b0, 5'd10, SRC_ALU, 1'b1, 5'd10});
      vecs.push_back('{2'd1, 1'b1, 1'b0, 5'd10, SRC_MEM, 1'b1, 5'd10});
      vecs.push_back('{2'd2, 1'b1, 1'b0, 5'd10, SRC_PC4, 1'b1, 5'd10});
      vecs.push_back('{2'd3, 1'b1, 1'b0, 5'd10, SRC_CSR, 1'b1, 5'd10});
      vecs.push_back('{2'd0, 1'b1, 1'b1, 5'd10, SRC_ALU, 1'b0, 5'd10});
      vecs.push_back('{2'd0, 1'b1, 1'b0, 5'd10, SRC_ALU, 1'b1, 5'd10});
      vecs.push_back('{2'd1, 1'b1, 1'b0, 5'd0,  SRC_MEM, 1'b0, 5'd0});
      vecs.push_back('{2'd2, 1'b1, 1'b0, 5'd31, SRC_PC4, 1'b1, 5'd31});
      vecs.push_back('{2'd3, 1'b0, 1'b0, 5'd7,  SRC_CSR, 1'b0, 5'd7});

      // Combinational table, with reset held so the history stays at zero
      rst = 1'b1;
      foreach (vecs[i]) begin
         @(negedge clk);
         wb_sel = vecs[i].sel; regwrite = vecs[i].rw;
         kill_wb = vecs[i].kill; rd_in = vecs[i].rd;
         #1;
         check($sformatf("vec%0d.rd_wdata", i), a_wdata, vecs[i].exp_wdata);
         check($sformatf("vec%0d.regwrite", i), {31'd0, a_we},
               {31'd0, vecs[i].exp_we});
         check($sformatf("vec%0d.rd_out", i), {27'd0, a_rd},
               {27'd0, vecs[i].exp_rd});
      end

      // HAS_CSR=0 instance on the CSR select, alongside the HAS_CSR=1 one
      @(negedge clk);
      wb_sel = 2'd3; regwrite = 1'b1; kill_wb = 1'b0; rd_in = 5'd12;
      #1;
      check("nocsr.rd_wdata", b_wdata, 32'h0);
      check("nocsr.regwrite", {31'd0, b_we}, 32'd1);
      check("nocsr.rd_out",   {27'd0, b_rd}, 32'd12);
      check("csr.rd_wdata",   a_wdata, SRC_CSR);
      check("nocsr.alu",      b_wdata, SRC_CSR & 32'h0);

      // History register sequences
      step("rst1",     1'b1, 2'd0, 1'b1, 1'b0, 5'd10);
      step("rst2",     1'b1, 2'd0, 1'b1, 1'b0, 5'd10);
      step("commit10", 1'b0, 2'd0, 1'b1, 1'b0, 5'd10);
      step("killed",   1'b0, 2'd1, 1'b1, 1'b1, 5'd11);
      step("x0write",  1'b0, 2'd2, 1'b1, 1'b0, 5'd0);
      step("b2b_a",    1'b0, 2'd1, 1'b1, 1'b0, 5'd5);
      step("b2b_b",    1'b0, 2'd2, 1'b1, 1'b0, 5'd6);
      step("csr31",    1'b0, 2'd3, 1'b1, 1'b0, 5'd31);
      step("norw",     1'b0, 2'd0, 1'b0, 1'b0, 5'd9);
      step("rst_over", 1'b1, 2'd1, 1'b1, 1'b0, 5'd20);
      step("post_rst", 1'b0, 2'd2, 1'b1, 1'b0, 5'd3);

      // No-CSR instance history after a CSR-select commit holds zero data
      step("nocsr_c",  1'b0, 2'd3, 1'b1, 1'b0, 5'd4);
      check("nocsr.wbq_valid", {31'd0, b_qvalid}, 32'd1);
      check("nocsr.wbq_rd",    {27'd0, b_qrd},    32'd4);
      check("nocsr.wbq_data",  b_qdata,           32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_wb_mux
`default_nettype wire
